// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: 50%-duty divided clock per channel with
// rise/fall strobes and glitch-free runtime ratio changes applied at the falling toggle.
module clk_div_prog #(
  parameter int unsigned CH       = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RST_HALF = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  input  logic [CH*CNT_W-1:0] half_div,
  input  logic [CH-1:0]       load,
  output logic [CH-1:0]       clk_div,
  output logic [CH-1:0]       rise_stb,
  output logic [CH-1:0]       shift_en,
  output logic [CH-1:0]       pend_vld
);

  localparam logic [CNT_W-1:0] RST_ACTIVE = CNT_W'(RST_HALF);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pend_q, pend_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;
    logic             shift_q, shift_d;
    logic [CNT_W-1:0] hd_c;
    logic             toggle_c;
    logic             fall_c;

    assign hd_c     = half_div[g*CNT_W +: CNT_W];
    assign toggle_c = (cnt_q == active_q);
    // Falling toggle is the only point where a new ratio may take effect while running.
    assign fall_c   = en[g] & toggle_c & lvl_q;

    always_comb begin
      cnt_d     = cnt_q;
      active_d  = active_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      lvl_d     = lvl_q;
      rise_d    = 1'b0;
      shift_d   = 1'b0;
      if (!en[g]) begin
        cnt_d = '0;
        lvl_d = 1'b0;
        if (load[g]) begin
          active_d = hd_c;
          pend_d   = 1'b0;
        end else if (pend_q) begin
          active_d = pending_q;
          pend_d   = 1'b0;
        end
      end else begin
        if (toggle_c) begin
          cnt_d   = '0;
          lvl_d   = ~lvl_q;
          rise_d  = ~lvl_q;
          shift_d = lvl_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (fall_c) begin
          // A load landing on the apply cycle bypasses the pending register.
          if (load[g]) begin
            active_d = hd_c;
          end else if (pend_q) begin
            active_d = pending_q;
          end
          pend_d = 1'b0;
        end else if (load[g]) begin
          pending_d = hd_c;
          pend_d    = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q     <= '0;
        active_q  <= RST_ACTIVE;
        pending_q <= '0;
        pend_q    <= 1'b0;
        lvl_q     <= 1'b0;
        rise_q    <= 1'b0;
        shift_q   <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        active_q  <= active_d;
        pending_q <= pending_d;
        pend_q    <= pend_d;
        lvl_q     <= lvl_d;
        rise_q    <= rise_d;
        shift_q   <= shift_d;
      end
    end

    assign clk_div[g]  = lvl_q;
    assign rise_stb[g] = rise_q;
    assign shift_en[g] = shift_q;
    assign pend_vld[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a phase-countdown reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_clk_div_prog;
  localparam int unsigned CH    = 2;
  localparam int unsigned CNT_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       en;
  logic [CH*CNT_W-1:0] half_div;
  logic [CH-1:0]       load;
  logic [CH-1:0]       clk_div;
  logic [CH-1:0]       rise_stb;
  logic [CH-1:0]       shift_en;
  logic [CH-1:0]       pend_vld;

  clk_div_prog #(.CH(CH), .CNT_W(CNT_W), .RST_HALF(15)) dut (
    .clk(clk), .rst(rst), .en(en), .half_div(half_div), .load(load),
    .clk_div(clk_div), .rise_stb(rise_stb), .shift_en(shift_en), .pend_vld(pend_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [4*CH-1:0] exp_q[$];

  // Reference: each half-period lasts H+1 enabled cycles, tracked as cycles left.
  int m_lvl[CH], m_rise[CH], m_fall[CH], m_h[CH], m_pend[CH], m_pv[CH], m_left[CH], m_run[CH];

  function automatic void model_edge(input logic r, input logic [CH-1:0] e,
                                     input logic [CH*CNT_W-1:0] hd, input logic [CH-1:0] ld);
    for (int i = 0; i < CH; i++) begin
      int nh;
      nh = int'(hd[i*CNT_W +: CNT_W]);
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (r) begin
        m_lvl[i] = 0; m_h[i] = 15; m_pend[i] = 0; m_pv[i] = 0; m_run[i] = 0;
      end else if (!e[i]) begin
        m_run[i] = 0; m_lvl[i] = 0;
        if (ld[i]) begin m_h[i] = nh; m_pv[i] = 0; end
        else if (m_pv[i] != 0) begin m_h[i] = m_pend[i]; m_pv[i] = 0; end
      end else begin
        if (m_run[i] == 0) begin m_run[i] = 1; m_left[i] = m_h[i] + 1; end
        m_left[i]--;
        if (m_left[i] == 0 && m_lvl[i] == 0) begin
          m_lvl[i] = 1; m_rise[i] = 1; m_left[i] = m_h[i] + 1;
          if (ld[i]) begin m_pend[i] = nh; m_pv[i] = 1; end
        end else if (m_left[i] == 0) begin
          m_lvl[i] = 0; m_fall[i] = 1;
          if (ld[i]) m_h[i] = nh;
          else if (m_pv[i] != 0) m_h[i] = m_pend[i];
          m_pv[i] = 0;
          m_left[i] = m_h[i] + 1;
        end else if (ld[i]) begin
          m_pend[i] = nh; m_pv[i] = 1;
        end
      end
    end
  endfunction

  function automatic logic [4*CH-1:0] model_out();
    logic [4*CH-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      v[3*CH+i] = (m_lvl[i] != 0);
      v[2*CH+i] = (m_rise[i] != 0);
      v[CH+i]   = (m_fall[i] != 0);
      v[i]      = (m_pv[i] != 0);
    end
    return v;
  endfunction

  function automatic logic [CH*CNT_W-1:0] pk(input int h0, input int h1);
    return {CNT_W'(h1), CNT_W'(h0)};
  endfunction

  task automatic step(input logic r, input logic [CH-1:0] e,
                      input logic [CH*CNT_W-1:0] hd, input logic [CH-1:0] ld);
    rst = r; en = e; half_div = hd; load = ld;
    model_edge(r, e, hd, ld);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  // Run enabled until channel ch is at level lvl with left edges before its toggle.
  task automatic run_until(input int ch, input int lvl, input int left);
    for (int k = 0; k < 300; k++) begin
      if (m_run[ch] != 0 && m_lvl[ch] == lvl && m_left[ch] == left) return;
      step(1'b0, '1, '0, '0);
    end
    checks++;
    errors++;
    $display("FAIL run_until ch%0d: condition not reached, got timeout want lvl=%0d left=%0d",
             ch, lvl, left);
  endtask

  always @(negedge clk) begin
    logic [4*CH-1:0] want, got;
    cyc++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {clk_div, rise_stb, shift_en, pend_vld};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cyc %0d {clk_div,rise,shift,pend}: got %b want %b", cyc, got, want);
      end
    end
  end

  initial begin
    logic [CH-1:0]       ren;
    logic [CH-1:0]       rld;
    logic [CH*CNT_W-1:0] rhd;
    logic                rrst;

    // Reset, then default divide-by-32 on both channels
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    repeat (80) step(1'b0, '1, '0, '0);

    // Divide-by-2 programmed while stopped
    step(1'b0, '0, pk(0, 0), '1);
    repeat (10) step(1'b0, '1, '0, '0);

    // H=3 on ch0, H=5 on ch1; then load H=7 on ch0 mid-high-phase
    step(1'b0, '0, pk(3, 5), '1);
    repeat (6) step(1'b0, '1, '0, '0);
    run_until(0, 1, 3);
    step(1'b0, '1, pk(7, 0), 2'b01);
    repeat (30) step(1'b0, '1, '0, '0);

    // Load landing exactly on ch0's falling toggle
    run_until(0, 1, 1);
    step(1'b0, '1, pk(2, 0), 2'b01);
    repeat (20) step(1'b0, '1, '0, '0);

    // Drop ch0 enable while high, then re-enable
    run_until(0, 1, 2);
    repeat (3) step(1'b0, 2'b10, '0, '0);
    repeat (20) step(1'b0, '1, '0, '0);

    // Reset mid-period with pending ratios on both channels
    run_until(1, 0, 2);
    step(1'b0, '1, pk(4, 9), '1);
    step(1'b0, '1, '0, '0);
    step(1'b1, '1, '0, '0);
    repeat (40) step(1'b0, '1, '0, '0);

    // Randomized traffic
    ren = '1;
    for (int n = 0; n < 3000; n++) begin
      rld = '0;
      rhd = '0;
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 39) == 0) ren[i] = ~ren[i];
        if ($urandom_range(0, 14) == 0) rld[i] = 1'b1;
        rhd[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
      end
      rrst = ($urandom_range(0, 399) == 0);
      step(rrst, ren, rhd, rld);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
